// File: rtl/cache_sdram_bridge.sv
// cache_sdram_bridge
// Memory-side responder for the L1 cache.
// - Writeback: serialises one 128-bit cache way into an 8 x 16-bit SDRAM write burst.
// - Fill: collects an 8-word SDRAM read burst back into a line.
// Only one transaction is in flight at a time.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           cache request handshake
//   req_write                     1 = writeback, 0 = fill
//   req_addr/req_wdata            line byte address, writeback data (w0 in the top bits)
//   rsp_valid/rsp_rdata           one-cycle completion pulse, last fill data (held)
//   sd_addr                       burst start word address
//   sd_rd_req/sd_wr_req/sd_ack    burst request, held until acknowledged
//   sd_wr_data/sd_wr_next         current write word, consumed when next is high
//   sd_rd_data/sd_rd_valid        incoming read word
//   proto_err                     sticky flag for controller strobes seen in the wrong state
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a request
// WR_REQ  | write burst requested, waiting for sd_ack; w0 presented
// WR_DATA | presenting w[cnt], advancing on sd_wr_next
// RD_REQ  | read burst requested, waiting for sd_ack
// RD_DATA | storing sd_rd_data into slot w[cnt] on sd_rd_valid
// RESP    | rsp_valid pulse, then back to IDLE
module cache_sdram_bridge #(
    parameter int LINE_W    = 128,
    parameter int WORD_W    = 16,
    parameter int BURST_LEN = 8,
    parameter int SADDR_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [31:0]        req_addr,
    input  logic [LINE_W-1:0]  req_wdata,
    output logic               rsp_valid,
    output logic [LINE_W-1:0]  rsp_rdata,
    output logic [SADDR_W-1:0] sd_addr,
    output logic               sd_rd_req,
    output logic               sd_wr_req,
    input  logic               sd_ack,
    output logic [WORD_W-1:0]  sd_wr_data,
    input  logic               sd_wr_next,
    input  logic [WORD_W-1:0]  sd_rd_data,
    input  logic               sd_rd_valid,
    output logic               proto_err
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int IDX_W = $clog2(LINE_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_DATA,
        RD_REQ,
        RD_DATA,
        RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  line_buf;
    logic [IDX_W-1:0]   slot_lsb;
    logic               unused_addr_bits;

    // Only the line-aligned word address bits reach the SDRAM side.
    assign unused_addr_bits = ^{req_addr[31:SADDR_W+1], req_addr[3:0]};

    // Word 0 lives in the most significant slot of the line.
    function automatic logic [WORD_W-1:0] word_at(input logic [LINE_W-1:0] line,
                                                  input logic [CNT_W-1:0]  idx);
        logic [IDX_W-1:0] lsb;
        lsb = IDX_W'((BURST_LEN - 1 - int'(idx)) * WORD_W);
        return line[lsb +: WORD_W];
    endfunction

    always_comb begin
        slot_lsb = IDX_W'((BURST_LEN - 1 - int'(cnt)) * WORD_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            line_buf   <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            sd_addr    <= '0;
            sd_rd_req  <= 1'b0;
            sd_wr_req  <= 1'b0;
            sd_wr_data <= '0;
            proto_err  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            if ((sd_ack      && state != WR_REQ && state != RD_REQ) ||
                (sd_wr_next  && state != WR_DATA) ||
                (sd_rd_valid && state != RD_DATA)) begin
                proto_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        sd_addr   <= {req_addr[SADDR_W:4], {CNT_W{1'b0}}};
                        line_buf  <= req_wdata;
                        if (req_write) begin
                            state      <= WR_REQ;
                            sd_wr_req  <= 1'b1;
                            sd_wr_data <= req_wdata[LINE_W-1 -: WORD_W];
                        end else begin
                            state     <= RD_REQ;
                            sd_rd_req <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (sd_ack) begin
                        sd_wr_req <= 1'b0;
                        state     <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (sd_wr_next) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            sd_wr_data <= word_at(line_buf, cnt + CNT_W'(1));
                        end
                    end
                end
                RD_REQ: begin
                    if (sd_ack) begin
                        sd_rd_req <= 1'b0;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (sd_rd_valid) begin
                        line_buf[slot_lsb +: WORD_W] <= sd_rd_data;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            // Last word fills the bottom slot; publish the merged line directly.
                            rsp_rdata <= {line_buf[LINE_W-1:WORD_W], sd_rd_data};
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
